// File: rtl/spi_pkg.sv
// Shared constants for the SPI master peripheral: register map,
// bit positions, CPU access codes and engine states.
package spi_pkg;

    localparam int W_CPU      = 32;
    localparam int W_REG      = 5;
    localparam int W_SPI_CTRL = 2;
    localparam int W_CTRLREG  = 6;
    localparam int W_STATUS   = 7;

    localparam logic [W_SPI_CTRL-1:0] CT_IDLE = 2'd0;
    localparam logic [W_SPI_CTRL-1:0] MT      = 2'd1;
    localparam logic [W_SPI_CTRL-1:0] MF      = 2'd2;

    localparam logic [W_REG-1:0] A_CTRL   = 5'd0;
    localparam logic [W_REG-1:0] A_DIV    = 5'd1;
    localparam logic [W_REG-1:0] A_TXDATA = 5'd2;
    localparam logic [W_REG-1:0] A_RXDATA = 5'd3;
    localparam logic [W_REG-1:0] A_STATUS = 5'd4;

    localparam int C_EN   = 0;
    localparam int C_CPOL = 1;
    localparam int C_CPHA = 2;
    localparam int C_LSBF = 3;
    localparam int C_TXIE = 4;
    localparam int C_RXIE = 5;

    localparam int S_TXOVF = 5;
    localparam int S_RXOVF = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD
    } spi_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous FIFO with an extra pointer bit for full/empty.
// Push on full and pop on empty are ignored.
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/spi_master_fifo_regfile.sv
// CPU-side SPI master: register file, TX/RX FIFOs, SCLK divider,
// frame engine FSM and shifters.
module spi_master_fifo_regfile
    import spi_pkg::*;
#(
    parameter int W_FRAME    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int W_DIV      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W_SPI_CTRL-1:0] ctrl,
    input  logic [W_REG-1:0]      addr,
    input  logic [W_CPU-1:0]      wd,
    output logic [W_CPU-1:0]      data_out,
    output logic                  spi_sclk,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic                  spi_cs_n,
    output logic                  irq
);

    localparam int HPW = $clog2(2 * W_FRAME);
    localparam int BCW = $clog2(W_FRAME);
    localparam logic [HPW-1:0] HP_LAST = HPW'(2 * W_FRAME - 1);
    localparam logic [BCW-1:0] BC_LAST = BCW'(W_FRAME - 1);

    spi_state_e state_q, state_d;

    logic [W_CTRLREG-1:0] ctrl_q;
    logic [W_DIV-1:0]     div_q, div_l_q, cnt_q;
    logic [W_CPU-1:0]     data_out_q, rd_data;
    logic                 txovf_q, rxovf_q;
    logic [HPW-1:0]       hp_q;
    logic [BCW-1:0]       bit_q;
    logic [W_FRAME-1:0]   tx_sh_q, rx_sh_q, tx_shifted, rx_next;
    logic                 cpol_q, cpha_q, lsbf_q, sclk_q;
    logic                 miso_s1_q, miso_s2_q;
    logic [1:0]           samp_q;

    logic wr, rd, busy, load, tick, edge_evt, lead;
    logic shift_evt, samp_evt, w1c;
    logic tx_push, tx_full, tx_empty;
    logic rx_push, rx_pop, rx_full, rx_empty;
    logic [W_FRAME-1:0] tx_rdata, rx_rdata;
    logic [W_STATUS-1:0] status;
    logic unused_wd;

    assign wr   = (ctrl == MT);
    assign rd   = (ctrl == MF);
    assign busy = (state_q != ST_IDLE);
    assign w1c  = wr && (addr == A_STATUS);
    assign unused_wd = ^wd;

    assign tx_push = wr && (addr == A_TXDATA);
    assign rx_pop  = rd && (addr == A_RXDATA) && !rx_empty;
    assign status  = {rxovf_q, txovf_q, busy, rx_full,
                      rx_empty, tx_full, tx_empty};

    spi_sync_fifo #(.WIDTH(W_FRAME), .DEPTH(FIFO_DEPTH)) u_tx (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (tx_push),
        .pop_i   (load),
        .wdata_i (wd[W_FRAME-1:0]),
        .rdata_o (tx_rdata),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    spi_sync_fifo #(.WIDTH(W_FRAME), .DEPTH(FIFO_DEPTH)) u_rx (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .wdata_i (rx_next),
        .rdata_o (rx_rdata),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    always_comb begin
        rd_data = '0;
        case (addr)
            A_CTRL:   rd_data = W_CPU'(ctrl_q);
            A_DIV:    rd_data = W_CPU'(div_q);
            A_RXDATA: rd_data = rx_empty ? '0 : W_CPU'(rx_rdata);
            A_STATUS: rd_data = W_CPU'(status);
            default:  rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q     <= '0;
            div_q      <= '0;
            txovf_q    <= 1'b0;
            rxovf_q    <= 1'b0;
            data_out_q <= '0;
        end else begin
            if (wr && addr == A_CTRL) ctrl_q <= wd[W_CTRLREG-1:0];
            if (wr && addr == A_DIV)  div_q  <= wd[W_DIV-1:0];
            txovf_q <= (tx_push && tx_full) ||
                       (txovf_q && !(w1c && wd[S_TXOVF]));
            rxovf_q <= (rx_push && rx_full) ||
                       (rxovf_q && !(w1c && wd[S_RXOVF]));
            if (rd) data_out_q <= rd_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        edge_evt = 1'b0;
        tick     = (cnt_q == div_l_q);
        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_q[C_EN] && !tx_empty) begin
                    load    = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tick) begin
                    edge_evt = 1'b1;
                    if (hp_q == HP_LAST) state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    if (ctrl_q[C_EN] && !tx_empty) begin
                        load    = 1'b1;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The first bit is already on MOSI from SETUP, so CPHA=1 skips the
    // shift on the very first leading edge.
    assign lead      = !hp_q[0];
    assign shift_evt = edge_evt &&
                       (cpha_q ? (lead && hp_q != '0) : !lead);
    assign samp_evt  = edge_evt && (cpha_q ? !lead : lead);

    assign tx_shifted = lsbf_q ? {1'b0, tx_sh_q[W_FRAME-1:1]}
                               : {tx_sh_q[W_FRAME-2:0], 1'b0};
    assign rx_next    = lsbf_q ? {miso_s2_q, rx_sh_q[W_FRAME-1:1]}
                               : {rx_sh_q[W_FRAME-2:0], miso_s2_q};

    // Capture two clocks after the SCLK sample edge to cancel the
    // MISO synchroniser latency.
    assign rx_push = samp_q[1] && (bit_q == BC_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            div_l_q   <= '0;
            hp_q      <= '0;
            bit_q     <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsbf_q    <= 1'b0;
            sclk_q    <= 1'b0;
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
            samp_q    <= '0;
        end else begin
            state_q   <= state_d;
            miso_s1_q <= spi_miso;
            miso_s2_q <= miso_s1_q;
            samp_q    <= {samp_q[0], samp_evt};
            if (samp_q[1]) begin
                rx_sh_q <= rx_next;
                bit_q   <= (bit_q == BC_LAST) ? '0 : bit_q + 1'b1;
            end
            if (load) begin
                tx_sh_q <= tx_rdata;
                cpol_q  <= ctrl_q[C_CPOL];
                cpha_q  <= ctrl_q[C_CPHA];
                lsbf_q  <= ctrl_q[C_LSBF];
                div_l_q <= div_q;
                sclk_q  <= ctrl_q[C_CPOL];
                cnt_q   <= '0;
            end else if (busy) begin
                cnt_q <= tick ? '0 : cnt_q + 1'b1;
                if (state_q == ST_SETUP && tick) hp_q <= '0;
                if (edge_evt) begin
                    sclk_q <= !sclk_q;
                    hp_q   <= hp_q + 1'b1;
                end
                if (shift_evt) tx_sh_q <= tx_shifted;
            end
        end
    end

    assign data_out = data_out_q;
    assign spi_cs_n = !busy;
    assign spi_sclk = busy ? sclk_q : ctrl_q[C_CPOL];
    assign spi_mosi = busy && (lsbf_q ? tx_sh_q[0]
                                      : tx_sh_q[W_FRAME-1]);
    assign irq = (!rx_empty && ctrl_q[C_RXIE]) ||
                 (tx_empty && ctrl_q[C_TXIE]);

endmodule

// File: tb/tb_spi_master_fifo_regfile.sv
// Bench for spi_master_fifo_regfile: register access, SPI modes,
// FIFO full/overflow, IRQ and asynchronous reset mid-frame.
module tb_spi_master_fifo_regfile;
    import spi_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [W_SPI_CTRL-1:0] ctrl;
    logic [W_REG-1:0]      addr;
    logic [W_CPU-1:0]      wd;
    logic [W_CPU-1:0]      data_out;
    logic                  spi_sclk, spi_mosi, spi_miso;
    logic                  spi_cs_n, irq;

    int miso_mode;
    assign spi_miso = (miso_mode == 0) ? spi_mosi : (miso_mode == 1);

    spi_master_fifo_regfile dut (
        .clk      (clk),
        .rst      (rst),
        .ctrl     (ctrl),
        .addr     (addr),
        .wd       (wd),
        .data_out (data_out),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_cs_n (spi_cs_n),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W_CPU-1:0] exp_rx[$];
    int rx_model_cnt = 0;
    int tx_pending = 0;

    logic        prev_sclk = 1'b0;
    logic        prev_cs = 1'b1;
    logic        hi_run = 1'b0;
    int          rise_cnt = 0;
    int          hi_cnt = 0;
    int          hi_bad = 0;
    int          cs_rise = 0;
    int          exp_hi = 2;
    logic [31:0] mon_word = '0;

    always @(negedge clk) begin
        if (!spi_cs_n && !prev_sclk && spi_sclk) begin
            rise_cnt++;
            mon_word = {mon_word[30:0], spi_mosi};
            hi_run = 1'b1;
            hi_cnt = 0;
        end
        if (hi_run && spi_sclk) hi_cnt++;
        if (hi_run && prev_sclk && !spi_sclk) begin
            if (hi_cnt != exp_hi) hi_bad++;
            hi_run = 1'b0;
        end
        if (!prev_cs && spi_cs_n) cs_rise++;
        prev_sclk = spi_sclk;
        prev_cs = spi_cs_n;
    end

    task automatic clear_mon();
        @(posedge clk);
        rise_cnt = 0;
        hi_bad = 0;
        hi_run = 1'b0;
        cs_rise = 0;
        mon_word = '0;
    endtask

    task automatic cpu_write(input logic [W_REG-1:0] a,
                             input logic [W_CPU-1:0] d);
        @(negedge clk);
        ctrl = MT;
        addr = a;
        wd = d;
        @(negedge clk);
        ctrl = CT_IDLE;
        wd = '0;
    endtask

    task automatic cpu_read(input logic [W_REG-1:0] a,
                            output logic [W_CPU-1:0] d);
        @(negedge clk);
        ctrl = MF;
        addr = a;
        @(negedge clk);
        ctrl = CT_IDLE;
        d = data_out;
    endtask

    task automatic model_push(input logic [7:0] v);
        logic [W_CPU-1:0] r;
        if (tx_pending >= 4) return;
        tx_pending++;
        r = (miso_mode == 0) ? W_CPU'(v) : (miso_mode == 1 ? 32'hFF : 32'h0);
        if (rx_model_cnt < 4) begin
            exp_rx.push_back(r);
            rx_model_cnt++;
        end
    endtask

    task automatic send(input logic [7:0] v);
        model_push(v);
        cpu_write(A_TXDATA, W_CPU'(v));
    endtask

    task automatic read_rx(input string name);
        logic [W_CPU-1:0] got, exp;
        exp = '0;
        if (exp_rx.size() > 0) begin
            exp = exp_rx.pop_front();
            rx_model_cnt--;
        end
        cpu_read(A_RXDATA, got);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_reg(input logic [W_REG-1:0] a,
                             input logic [W_CPU-1:0] exp,
                             input string name);
        logic [W_CPU-1:0] got;
        cpu_read(a, got);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_idle();
        logic [W_CPU-1:0] s;
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            cpu_read(A_STATUS, s);
            if (!s[4] && s[0]) done = 1;
        end
        tx_pending = 0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_idle: got busy expected idle");
        end
    endtask

    task automatic test_reset();
        logic [4:0] got;
        rst = 1'b0;
        ctrl = CT_IDLE;
        addr = '0;
        wd = '0;
        miso_mode = 0;
        repeat (3) @(negedge clk);
        got = {data_out == '0, spi_sclk, spi_mosi, spi_cs_n, irq};
        checks++;
        if (got !== 5'b10010) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 10010", got);
        end
        @(negedge clk);
        rst = 1'b1;
        check_reg(A_STATUS, 32'h05, "reset_status");
        check_reg(A_CTRL, 32'h00, "reset_ctrl");
        check_reg(A_DIV, 32'h00, "reset_div");
    endtask

    task automatic test_mode0_loop();
        miso_mode = 0;
        exp_hi = 2;
        cpu_write(A_DIV, 32'd1);
        cpu_write(A_CTRL, 32'h01);
        clear_mon();
        model_push(8'hA5);
        @(negedge clk);
        ctrl = MT;
        addr = A_TXDATA;
        wd = 32'hA5;
        @(negedge clk);
        ctrl = CT_IDLE;
        checks++;
        if (spi_cs_n !== 1'b1) begin
            errors++;
            $display("FAIL cs_edge_n: got %b expected 1", spi_cs_n);
        end
        @(negedge clk);
        checks++;
        if (spi_cs_n !== 1'b0) begin
            errors++;
            $display("FAIL cs_edge_n1: got %b expected 0", spi_cs_n);
        end
        wait_idle();
        checks++;
        if (rise_cnt != 8 || hi_bad != 0) begin
            errors++;
            $display("FAIL mode0_sclk: got rises %0d bad %0d expected 8 0",
                     rise_cnt, hi_bad);
        end
        checks++;
        if (mon_word[7:0] !== 8'hA5) begin
            errors++;
            $display("FAIL mode0_mosi: got %h expected a5", mon_word[7:0]);
        end
        read_rx("mode0_rx");
    endtask

    task automatic test_mode3();
        miso_mode = 1;
        cpu_write(A_CTRL, 32'h07);
        checks++;
        if (spi_sclk !== 1'b1) begin
            errors++;
            $display("FAIL mode3_idle: got %b expected 1", spi_sclk);
        end
        clear_mon();
        send(8'h3C);
        wait_idle();
        checks++;
        if (rise_cnt != 8 || mon_word[7:0] !== 8'h3C) begin
            errors++;
            $display("FAIL mode3_mosi: got %0d %h expected 8 3c",
                     rise_cnt, mon_word[7:0]);
        end
        read_rx("mode3_rx");
    endtask

    task automatic test_lsbf();
        miso_mode = 0;
        cpu_write(A_CTRL, 32'h09);
        clear_mon();
        send(8'h80);
        wait_idle();
        checks++;
        if (mon_word[7:0] !== 8'h01) begin
            errors++;
            $display("FAIL lsbf_mosi: got %h expected 01", mon_word[7:0]);
        end
        read_rx("lsbf_rx");
    endtask

    task automatic test_irq();
        cpu_write(A_CTRL, 32'h10);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_tx: got %b expected 1", irq);
        end
        cpu_write(A_CTRL, 32'h20);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_rx_empty: got %b expected 0", irq);
        end
    endtask

    task automatic test_tx_full();
        miso_mode = 0;
        cpu_write(A_CTRL, 32'h00);
        for (int i = 1; i <= 5; i++) send(8'(i));
        check_reg(A_STATUS, 32'h26, "txfull_status");
        cpu_write(A_STATUS, 32'h20);
        check_reg(A_STATUS, 32'h06, "txovf_clear");
        clear_mon();
        cpu_write(A_CTRL, 32'h01);
        wait_idle();
        checks++;
        if (cs_rise != 1 || rise_cnt != 32) begin
            errors++;
            $display("FAIL b2b_cs: got cs_rise %0d rises %0d expected 1 32",
                     cs_rise, rise_cnt);
        end
        check_reg(A_STATUS, 32'h09, "b2b_status");
    endtask

    task automatic test_rx_overflow();
        send(8'h05);
        wait_idle();
        check_reg(A_STATUS, 32'h49, "rxovf_status");
        cpu_write(A_CTRL, 32'h20);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_rx: got %b expected 1", irq);
        end
        for (int i = 0; i < 5; i++) read_rx($sformatf("rx_drain%0d", i));
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_drained: got %b expected 0", irq);
        end
        cpu_write(A_STATUS, 32'h40);
        check_reg(A_STATUS, 32'h05, "rxovf_clear");
    endtask

    task automatic test_reset_midframe();
        bit seen = 0;
        logic [3:0] got;
        miso_mode = 0;
        cpu_write(A_CTRL, 32'h01);
        clear_mon();
        cpu_write(A_TXDATA, 32'hFF);
        for (int i = 0; i < 500 && !seen; i++) begin
            @(posedge clk);
            if (rise_cnt >= 4) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midframe_wait: got %0d rises expected 4", rise_cnt);
        end
        #2;
        rst = 1'b0;
        #1;
        got = {spi_cs_n, spi_sclk, spi_mosi, data_out == '0};
        checks++;
        if (got !== 4'b1001) begin
            errors++;
            $display("FAIL midframe_reset: got %b expected 1001", got);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_rx.delete();
        rx_model_cnt = 0;
        tx_pending = 0;
        check_reg(A_STATUS, 32'h05, "post_reset_status");
    endtask

    initial begin
        test_reset();
        test_mode0_loop();
        test_mode3();
        test_lsbf();
        test_irq();
        test_tx_full();
        test_rx_overflow();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
